// File: rtl/map_server.sv
// map_server: 16x16 tile map with loader port and single-agent move arbitration;
// defining MAP_SERVER_STATS_EN adds ack_cnt/nack_cnt response counters.
module map_server (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic [1:0]  req_type,
    input  logic [7:0]  req_content,
    input  logic [15:0] digger_status,
    input  logic        ld_en,
    input  logic [7:0]  ld_addr,
    input  logic [15:0] ld_data,
    output logic        ACK,
    output logic        NACK,
    output logic        wr,
    output logic [15:0] data_out,
    output logic        ready
`ifdef MAP_SERVER_STATS_EN
    ,
    output logic [7:0]  ack_cnt,
    output logic [7:0]  nack_cnt
`endif
);
    typedef enum logic [2:0] {INIT, IDLE, LOOKUP, RESPOND, WAIT_DROP} state_t;
    state_t state;
    logic [15:0] mem [256];
    logic [15:0] rdata, wd, resp;
    logic [255:0] occ;
    logic [7:0] pos, init_addr, tgt, wa;
    logic [1:0] typ;
    logic pos_v, we, rd, catch_hit, same, ok, mv;
    logic unused_status;
    assign unused_status = ^digger_status[15:8];
    always_comb begin
        we = !rst && (state == INIT || (state == IDLE && ld_en));
        rd = !rst && state == IDLE && req && !ld_en;
        wa = state == INIT ? init_addr : ld_addr;
        wd = state == INIT ? 16'h0000 : ld_data;
    end
    always_ff @(posedge clk) begin
        if (we) mem[wa] <= wd;
        if (rd) rdata <= mem[req_content];
    end
    // move priority: catch, then stay-in-place, then occupied, then free
    always_comb begin
        catch_hit = tgt == digger_status[7:0];
        same = pos_v && tgt == pos;
        ok = typ != 2'b11 && !(typ == 2'b01 && !catch_hit && !same && occ[tgt]);
        mv = typ == 2'b01 && !catch_hit && !same && !occ[tgt];
        resp = typ == 2'b10 ? {7'b0, pos_v, pos} : (typ == 2'b01 && catch_hit) ? 16'hFFFF : rdata;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            init_addr <= 8'd0;
            ready <= 1'b0;
            ACK <= 1'b0;
            NACK <= 1'b0;
            wr <= 1'b0;
            data_out <= 16'h0000;
            occ <= '0;
            pos <= 8'd0;
            pos_v <= 1'b0;
            typ <= 2'b00;
            tgt <= 8'd0;
        end else begin
            ACK <= 1'b0;
            NACK <= 1'b0;
            wr <= 1'b0;
            case (state)
                INIT: begin
                    init_addr <= init_addr + 8'd1;
                    if (init_addr == 8'hFF) begin
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                IDLE: if (req && !ld_en) begin
                    typ <= req_type;
                    tgt <= req_content;
                    state <= LOOKUP;
                end
                LOOKUP: state <= RESPOND;
                RESPOND: begin
                    state <= WAIT_DROP;
                    ACK <= ok;
                    NACK <= !ok;
                    wr <= ok;
                    if (ok) data_out <= resp;
                    if (mv) begin
                        if (pos_v) occ[pos] <= 1'b0;
                        occ[tgt] <= 1'b1;
                        pos <= tgt;
                        pos_v <= 1'b1;
                    end
                end
                WAIT_DROP: if (!req) state <= IDLE;
                default: state <= INIT;
            endcase
        end
    end
`ifdef MAP_SERVER_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ack_cnt <= 8'd0;
            nack_cnt <= 8'd0;
        end else if (state == RESPOND) begin
            if (ok) ack_cnt <= ack_cnt + 8'd1;
            else nack_cnt <= nack_cnt + 8'd1;
        end
    end
`endif
endmodule

// File: tb/tb_map_server.sv
// tb_map_server: directed self-checking bench for map_server.
module tb_map_server;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  req_type = 2'b00;
    logic [7:0]  req_content = 8'h00;
    logic [15:0] digger_status = 16'h5DCF;
    logic        ld_en = 1'b0;
    logic [7:0]  ld_addr = 8'h00;
    logic [15:0] ld_data = 16'h0000;
    logic        ACK, NACK, wr, ready;
    logic [15:0] data_out;
`ifdef MAP_SERVER_STATS_EN
    logic [7:0]  ack_cnt, nack_cnt;
`endif
    int compared = 0;
    int mismatched = 0;
    int extra, lat;
    logic a, n, w, any_resp;
    logic [15:0] d;

    map_server dut (
        .clk(clk), .rst(rst), .req(req), .req_type(req_type), .req_content(req_content),
        .digger_status(digger_status), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .ACK(ACK), .NACK(NACK), .wr(wr), .data_out(data_out), .ready(ready)
`ifdef MAP_SERVER_STATS_EN
        , .ack_cnt(ack_cnt), .nack_cnt(nack_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [7:0] addr, input logic [15:0] data);
        ld_en = 1'b1;
        ld_addr = addr;
        ld_data = data;
        step();
        ld_en = 1'b0;
    endtask

    // one request held until the response, then three extra held cycles, then dropped
    task automatic txn(input logic [1:0] t, input logic [7:0] c, input logic ld, input logic [15:0] ldd);
        req = 1'b1;
        req_type = t;
        req_content = c;
        ld_en = ld;
        ld_addr = c;
        ld_data = ldd;
        lat = 0;
        a = 1'b0;
        n = 1'b0;
        w = 1'b0;
        d = 16'hxxxx;
        for (int i = 1; i <= 8; i++) begin
            step();
            ld_en = 1'b0;
            if (ACK || NACK) begin
                lat = i;
                a = ACK;
                n = NACK;
                w = wr;
                d = data_out;
                break;
            end
        end
        extra = 0;
        repeat (3) begin
            step();
            if (ACK || NACK || wr) extra++;
        end
        req = 1'b0;
        step();
    endtask

    initial begin
        step();
        check("rst_ready", ready, 0);
        check("rst_data", data_out, 0);
        check("rst_ack", {ACK, NACK, wr}, 0);
        rst = 1'b0;
        ld_en = 1'b1;
        ld_addr = 8'h10;
        ld_data = 16'hBEEF;
        req = 1'b1;
        any_resp = 1'b0;
        for (int i = 0; i < 255; i++) begin
            step();
            any_resp |= ACK | NACK | wr;
        end
        check("init_not_ready_255", ready, 0);
        ld_en = 1'b0;
        req = 1'b0;
        step();
        any_resp |= ACK | NACK | wr;
        check("init_ready_256", ready, 1);
        check("init_no_resp", any_resp, 0);
        step();

        txn(2'b00, 8'h10, 1'b0, 16'h0);
        check("init_ignores_ld", d, 16'h0000);
        load(8'h38, 16'h0024);
        check("load_no_ack", {ACK, NACK, wr}, 0);
        txn(2'b00, 8'h38, 1'b0, 16'h0);
        check("read_lat", lat, 3);
        check("read_ack_wr", {a, n, w}, 3'b101);
        check("read_data", d, 16'h0024);
        check("read_no_second", extra, 0);

        load(8'h4F, 16'h1111);
        load(8'h50, 16'h2222);
        txn(2'b01, 8'h4F, 1'b0, 16'h0);
        check("move4f_ack", {a, n, w}, 3'b101);
        check("move4f_data", d, 16'h1111);
        txn(2'b01, 8'h50, 1'b0, 16'h0);
        check("move50_ack", {a, n, w}, 3'b101);
        check("move50_data", d, 16'h2222);
        check("occ_4f", dut.occ[8'h4F], 0);
        check("occ_50", dut.occ[8'h50], 1);
        txn(2'b10, 8'h00, 1'b0, 16'h0);
        check("query_pos", d, 16'h0150);
        txn(2'b01, 8'h50, 1'b0, 16'h0);
        check("move_same_ack", {a, n, w}, 3'b101);
        check("move_same_data", d, 16'h2222);

        txn(2'b01, 8'hCF, 1'b0, 16'h0);
        check("catch_ack", {a, n, w}, 3'b101);
        check("catch_data", d, 16'hFFFF);
        txn(2'b10, 8'h00, 1'b0, 16'h0);
        check("catch_pos_kept", d, 16'h0150);
        txn(2'b11, 8'h00, 1'b0, 16'h0);
        check("reserved_nack", {a, n, w}, 3'b010);
        check("nack_lat", lat, 3);
        check("nack_data_held", data_out, 16'h0150);

        txn(2'b00, 8'h60, 1'b1, 16'hABCD);
        check("ld_win_lat", lat, 4);
        check("ld_win_data", d, 16'hABCD);

        req = 1'b1;
        req_type = 2'b00;
        req_content = 8'h38;
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        req = 1'b0;
        any_resp = 1'b0;
        repeat (5) begin
            step();
            any_resp |= ACK | NACK | wr;
        end
        check("abort_no_resp", any_resp, 0);
        check("abort_ready_low", ready, 0);
        check("abort_data_clr", data_out, 0);
        for (int i = 0; i < 300 && !ready; i++) step();
        check("reinit_ready", ready, 1);
        txn(2'b10, 8'h00, 1'b0, 16'h0);
        check("reinit_pos", d, 16'h0000);
        txn(2'b00, 8'h38, 1'b0, 16'h0);
        check("reinit_tile", d, 16'h0000);
`ifdef MAP_SERVER_STATS_EN
        txn(2'b11, 8'h00, 1'b0, 16'h0);
        txn(2'b00, 8'h01, 1'b0, 16'h0);
        check("ack_cnt_3", ack_cnt, 3);
        check("nack_cnt_1", nack_cnt, 1);
        repeat (253) txn(2'b00, 8'h02, 1'b0, 16'h0);
        check("ack_cnt_wrap", ack_cnt, 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
